// File: rtl/epp_host_port.sv
// EPP slave front-end: synchronizes the raw EPP pins, decodes address/data cycles
// and turns each data strobe into one req/ack transaction on the core register bus.
module epp_host_port #(
    parameter int SYNC_LEVEL = 2,
    parameter int ADDR_BITS  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EPP_ASTB,
    input  logic                 EPP_DSTB,
    input  logic                 EPP_WR,
    inout  wire  [7:0]           EPP_D,
    output logic                 EPP_WAIT,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic                 wr_req,
    output logic [7:0]           wr_data,
    input  logic                 wr_ack,
    output logic                 rd_req,
    input  logic [7:0]           rd_data,
    input  logic                 rd_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_WR = 2'd1,
        CORE_RD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Pin bundle layout: {astb, dstb, wr, d[7:0]}
    logic [10:0] pins_s;
    logic [10:0] sync_r [SYNC_LEVEL];
    logic [10:0] samp_r;

    logic       astb_s;
    logic       dstb_s;
    logic       wr_s;
    logic [7:0] d_s;

    state_t                 state_r,    state_s;
    logic                   epp_wait_r;
    logic                   rd_oe_r,    rd_oe_s;
    logic                   wr_req_r,   wr_req_s;
    logic                   rd_req_r,   rd_req_s;
    logic [ADDR_BITS-1:0]   reg_addr_r, reg_addr_s;
    logic [7:0]             wr_data_r,  wr_data_s;
    logic [7:0]             rdata_r,    rdata_s;

    assign pins_s = {EPP_ASTB, EPP_DSTB, EPP_WR, EPP_D};

    // Synchronizer chain plus sample register; idle level is all ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_LEVEL; i++) begin
                sync_r[i] <= {11{1'b1}};
            end
            samp_r <= {11{1'b1}};
        end else begin
            sync_r[0] <= pins_s;
            for (int i = 1; i < SYNC_LEVEL; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            samp_r <= sync_r[SYNC_LEVEL-1];
        end
    end

    assign astb_s = samp_r[10];
    assign dstb_s = samp_r[9];
    assign wr_s   = samp_r[8];
    assign d_s    = samp_r[7:0];

    // Next-state and next-register logic for the host/core handshake
    always_comb begin
        state_s    = state_r;
        rd_oe_s    = rd_oe_r;
        wr_req_s   = wr_req_r;
        rd_req_s   = rd_req_r;
        reg_addr_s = reg_addr_r;
        wr_data_s  = wr_data_r;
        rdata_s    = rdata_r;
        case (state_r)
            IDLE: begin
                // Address strobe wins over a simultaneous data strobe
                if (!astb_s && !wr_s) begin
                    if ((d_s >> ADDR_BITS) == 8'h00) begin
                        reg_addr_s = d_s[ADDR_BITS-1:0];
                    end else begin
                        reg_addr_s = reg_addr_r;
                    end
                    state_s = HOLD;
                end else if (!astb_s && wr_s) begin
                    rdata_s                 = 8'h00;
                    rdata_s[ADDR_BITS-1:0]  = reg_addr_r;
                    rd_oe_s                 = 1'b1;
                    state_s                 = HOLD;
                end else if (!dstb_s && !wr_s) begin
                    wr_data_s = d_s;
                    wr_req_s  = 1'b1;
                    state_s   = CORE_WR;
                end else if (!dstb_s && wr_s) begin
                    rd_req_s = 1'b1;
                    state_s  = CORE_RD;
                end else begin
                    state_s = IDLE;
                end
            end
            CORE_WR: begin
                if (wr_ack) begin
                    wr_req_s = 1'b0;
                    state_s  = HOLD;
                end else begin
                    state_s = CORE_WR;
                end
            end
            CORE_RD: begin
                if (rd_ack) begin
                    rdata_s  = rd_data;
                    rd_oe_s  = 1'b1;
                    rd_req_s = 1'b0;
                    state_s  = HOLD;
                end else begin
                    state_s = CORE_RD;
                end
            end
            HOLD: begin
                // Only both strobes idle ends the cycle, so a held strobe never retriggers
                if (astb_s && dstb_s) begin
                    rd_oe_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s  = IDLE;
                rd_oe_s  = 1'b0;
                wr_req_s = 1'b0;
                rd_req_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            epp_wait_r <= 1'b0;
            rd_oe_r    <= 1'b0;
            wr_req_r   <= 1'b0;
            rd_req_r   <= 1'b0;
            reg_addr_r <= {ADDR_BITS{1'b0}};
            wr_data_r  <= 8'h00;
            rdata_r    <= 8'h00;
        end else begin
            state_r    <= state_s;
            epp_wait_r <= (state_s == HOLD);
            rd_oe_r    <= rd_oe_s;
            wr_req_r   <= wr_req_s;
            rd_req_r   <= rd_req_s;
            reg_addr_r <= reg_addr_s;
            wr_data_r  <= wr_data_s;
            rdata_r    <= rdata_s;
        end
    end

    assign EPP_WAIT = epp_wait_r;
    assign reg_addr = reg_addr_r;
    assign wr_req   = wr_req_r;
    assign wr_data  = wr_data_r;
    assign rd_req   = rd_req_r;
    assign EPP_D    = rd_oe_r ? rdata_r : 8'hzz;

endmodule

// File: tb/tb_epp_host_port.sv
// Bench for epp_host_port: host-side EPP driver, core-side responders, and a
// scoreboard fed by a transaction-level model of the register address and bus data.
module tb_epp_host_port;

    localparam int SL = 2;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          astb = 1'b1;
    logic          dstb = 1'b1;
    logic          wr_pin = 1'b1;
    logic          host_oe = 1'b0;
    logic [7:0]    host_d = 8'h00;
    wire  [7:0]    epp_d;
    logic          epp_wait;
    logic [AB-1:0] reg_addr;
    logic          wr_req;
    logic [7:0]    wr_data;
    logic          wr_ack = 1'b0;
    logic          rd_req;
    logic [7:0]    rd_data = 8'h00;
    logic          rd_ack = 1'b0;

    assign epp_d = host_oe ? host_d : 8'hzz;
    pullup (epp_d);

    always #5 clk = ~clk;

    epp_host_port #(.SYNC_LEVEL(SL), .ADDR_BITS(AB)) dut (
        .CLK(clk), .RST(rst),
        .EPP_ASTB(astb), .EPP_DSTB(dstb), .EPP_WR(wr_pin), .EPP_D(epp_d),
        .EPP_WAIT(epp_wait), .reg_addr(reg_addr),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack)
    );

    typedef struct { int kind; int addr; int bus; } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   wdata_q[$];
    int   model_addr = 0;
    int   wr_count = 0;
    int   rd_count = 0;
    int   cur_wdelay = 0;
    int   cur_rdelay = 0;
    int   cur_rdata = 0;
    bit   rd_busy = 1'b0;
    bit   aborted = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each EPP_WAIT rise completes one expected host cycle
    initial begin : wait_monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && epp_wait && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wait", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("reg_addr", int'(reg_addr), e.addr);
                    if (e.bus >= 0) check("bus_read", int'(epp_d), e.bus);
                end
            end
            prev = epp_wait;
        end
    end

    // Core write responder: checks write data and request length, acks after cur_wdelay
    initial begin : wr_core
        int n;
        int want;
        forever begin
            @(negedge clk);
            if (wr_req === 1'b1 && !rst) begin
                wr_count++;
                want = -1;
                if (wdata_q.size() > 0) want = wdata_q.pop_front();
                check("wr_data", int'(wr_data), want);
                n = 1;
                repeat (cur_wdelay) begin
                    @(negedge clk);
                    if (wr_req) n++;
                end
                check("wr_data_hold", int'(wr_data), want);
                wr_ack = 1'b1;
                @(negedge clk);
                wr_ack = 1'b0;
                check("wr_req_cycles", n, cur_wdelay + 1);
                check("wr_req_drop", int'(wr_req), 0);
            end
        end
    end

    // Core read responder: returns cur_rdata after cur_rdelay, then garbage on rd_data
    initial begin : rd_core
        int n;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1 && !rst) begin
                rd_busy = 1'b1;
                rd_count++;
                n = 1;
                repeat (cur_rdelay) begin
                    @(negedge clk);
                    if (rd_req) n++;
                end
                rd_data = 8'(cur_rdata);
                rd_ack  = 1'b1;
                @(negedge clk);
                rd_ack  = 1'b0;
                rd_data = ~8'(cur_rdata);
                if (!aborted) begin
                    check("rd_req_cycles", n, cur_rdelay + 1);
                    check("rd_req_drop", int'(rd_req), 0);
                end
                rd_busy = 1'b0;
            end
        end
    end

    // kind: 0 addr write, 1 addr read, 2 data write, 3 data read, 4 both strobes (write)
    task automatic host_cycle(input int kind, input int val, input int hold, input int early,
                              input int wdelay, input int rdelay, input int rval);
        int   cnt;
        int   exp_rise;
        int   wr0;
        int   rd0;
        exp_t e;
        cur_wdelay = wdelay;
        cur_rdelay = rdelay;
        cur_rdata  = rval;
        wr0 = wr_count;
        rd0 = rd_count;
        e.kind = kind;
        e.bus  = -1;
        case (kind)
            0, 4: if (val < (1 << AB)) model_addr = val;
            1: e.bus = model_addr;
            2: wdata_q.push_back(val);
            3: e.bus = rval;
            default: ;
        endcase
        e.addr = model_addr;
        exp_q.push_back(e);
        if (kind == 2)      exp_rise = SL + 3 + wdelay;
        else if (kind == 3) exp_rise = SL + 3 + rdelay;
        else                exp_rise = SL + 2;

        @(negedge clk);
        wr_pin  = (kind == 1 || kind == 3);
        host_d  = 8'(val);
        host_oe = !(kind == 1 || kind == 3);
        astb    = !(kind == 0 || kind == 1 || kind == 4);
        dstb    = !(kind == 2 || kind == 3 || kind == 4);
        cnt = 0;
        if (early > 0) begin
            repeat (early) @(negedge clk);
            astb = 1'b1; dstb = 1'b1; host_oe = 1'b0;
            cnt = early;
        end
        while (!epp_wait && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_rise_cycles", cnt, exp_rise);
        if (early > 0) begin
            @(negedge clk);
            check("wait_early_width", int'(epp_wait), 0);
        end else begin
            repeat (hold) @(negedge clk);
            astb = 1'b1; dstb = 1'b1; host_oe = 1'b0;
            cnt = 0;
            while (epp_wait && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            check("wait_fall_cycles", cnt, SL + 2);
        end
        check("bus_hiz", int'(epp_d), 8'hFF);
        check("wr_reqs", wr_count - wr0, (kind == 2) ? 1 : 0);
        check("rd_reqs", rd_count - rd0, (kind == 3) ? 1 : 0);
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want done");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt;
        int k;
        int v;
        repeat (3) @(negedge clk);
        check("rst_wait", int'(epp_wait), 0);
        check("rst_addr", int'(reg_addr), 0);
        check("rst_wr_req", int'(wr_req), 0);
        check("rst_rd_req", int'(rd_req), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_bus", int'(epp_d), 8'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        host_cycle(0, 8'h0D, 14, 0, 0, 0, 0);
        host_cycle(0, 8'h3A, 5, 0, 0, 0, 0);
        host_cycle(2, 8'h55, 3, 0, 5, 0, 0);
        host_cycle(3, 0, 3, 0, 0, 3, 8'hA7);
        host_cycle(0, 8'h07, 2, 0, 0, 0, 0);
        host_cycle(1, 0, 2, 0, 0, 0, 0);

        // Reset while the core read is outstanding
        aborted = 1'b1;
        cur_rdelay = 30;
        cur_rdata = 8'h3C;
        @(negedge clk);
        wr_pin = 1'b1; host_oe = 1'b0; dstb = 1'b0;
        cnt = 0;
        while (!rd_req && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rd_req_rise", cnt, SL + 2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rd_req", int'(rd_req), 0);
        check("mid_rst_wait", int'(epp_wait), 0);
        check("mid_rst_bus", int'(epp_d), 8'hFF);
        check("mid_rst_addr", int'(reg_addr), 0);
        dstb = 1'b1;
        model_addr = 0;
        cnt = 0;
        while (rd_busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_done", int'(rd_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b0;
        repeat (2) @(negedge clk);

        host_cycle(1, 0, 1, 0, 0, 0, 0);
        host_cycle(4, 8'h02, 4, 0, 0, 0, 0);
        host_cycle(1, 0, 1, 0, 0, 0, 0);
        host_cycle(2, 8'hC3, 0, 6, 15, 0, 0);
        host_cycle(3, 0, 0, 6, 0, 15, 8'h5A);
        host_cycle(2, 8'h81, 0, 0, 0, 0, 0);
        host_cycle(3, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 3);
            if (k < 2 && $urandom_range(0, 1) == 1) v = $urandom_range(0, 15);
            else v = $urandom_range(0, 255);
            host_cycle(k, v, $urandom_range(0, 4), 0, $urandom_range(0, 6),
                       $urandom_range(0, 6), $urandom_range(0, 254));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
